// File: rtl/cnn_layer_accel_trans_eg_sync_fifo.sv
// Synchronous FIFO for layer-transfer entries. Metadata and payload share one word and one
// address, so the fields cannot drift apart. Status flags are registered from the next count.
module cnn_layer_accel_trans_eg_sync_fifo #(
    parameter int META_WIDTH   = 64,
    parameter int PYLD_WIDTH   = 1024,
    parameter int DEPTH        = 512,
    parameter int AF_THRESH    = DEPTH - 4,
    parameter int AE_THRESH    = 4,
    parameter int RST_BUSY_CYC = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [META_WIDTH+PYLD_WIDTH-1:0]   din,
    input  logic                               wr_en,
    input  logic                               rd_en,
    output logic [META_WIDTH+PYLD_WIDTH-1:0]   dout,
    output logic                               valid,
    output logic                               full,
    output logic                               empty,
    output logic                               almost_full,
    output logic                               almost_empty,
    output logic [$clog2(DEPTH):0]             data_count,
    output logic                               overflow,
    output logic                               underflow,
    output logic                               rst_busy
);
    localparam int DW = META_WIDTH + PYLD_WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C      = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C      = CW'(AE_THRESH);
    localparam logic [3:0]    BUSY_INIT = 4'(RST_BUSY_CYC);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_data_q;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          valid_q, valid_d;
    logic          dout_zero_q, dout_zero_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          af_q, af_d;
    logic          ae_q, ae_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          busy_q, busy_d;
    logic [3:0]    busy_cnt_q, busy_cnt_d;

    logic wr_acc;
    logic rd_acc;

    // Acceptance uses the registered flags, so a full FIFO drops a write even when a read
    // frees a slot in the same cycle, and an empty FIFO never falls a write through.
    assign wr_acc = wr_en & ~full_q  & ~busy_q & ~rst;
    assign rd_acc = rd_en & ~empty_q & ~busy_q & ~rst;

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= din;
        end
        if (rd_acc) begin
            rd_data_q <= mem[rd_ptr_q];
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q + AW'(wr_acc);
        rd_ptr_d    = rd_ptr_q + AW'(rd_acc);
        count_d     = count_q + CW'(wr_acc) - CW'(rd_acc);
        valid_d     = rd_acc;
        dout_zero_d = dout_zero_q & ~rd_acc;
        full_d      = (count_d == DEPTH_C);
        empty_d     = (count_d == '0);
        af_d        = (count_d >= AF_C);
        ae_d        = (count_d <= AE_C);
        ovf_d       = ovf_q | (wr_en & full_q  & ~busy_q);
        unf_d       = unf_q | (rd_en & empty_q & ~busy_q);
        busy_cnt_d  = busy_cnt_q - 4'(busy_cnt_q != 4'd0);
        busy_d      = (busy_cnt_q > 4'd1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            valid_q     <= 1'b0;
            dout_zero_q <= 1'b1;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            af_q        <= 1'b0;
            ae_q        <= 1'b1;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            busy_q      <= 1'b1;
            busy_cnt_q  <= BUSY_INIT;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            valid_q     <= valid_d;
            dout_zero_q <= dout_zero_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            af_q        <= af_d;
            ae_q        <= ae_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            busy_q      <= busy_d;
            busy_cnt_q  <= busy_cnt_d;
        end
    end

    // The RAM output register has no reset; dout reads as zero until the first read after reset.
    assign dout         = dout_zero_q ? '0 : rd_data_q;
    assign valid        = valid_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign data_count   = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
    assign rst_busy     = busy_q;

endmodule

// File: tb/tb_cnn_layer_accel_trans_eg_sync_fifo.sv
// Randomized bench for the sync FIFO: every cycle is compared against a queue-based model
// of the FIFO contract, plus directed boundary checks (fill, drain, full/empty collisions, reset).
module tb_cnn_layer_accel_trans_eg_sync_fifo;
    localparam int MW    = 8;
    localparam int PW    = 16;
    localparam int DW    = MW + PW;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 4;
    localparam int BUSY  = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic [DW-1:0] din;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] dout;
    logic          valid;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic [CW-1:0] data_count;
    logic          overflow;
    logic          underflow;
    logic          rst_busy;

    cnn_layer_accel_trans_eg_sync_fifo #(
        .META_WIDTH(MW), .PYLD_WIDTH(PW), .DEPTH(DEPTH),
        .AF_THRESH(AF), .AE_THRESH(AE), .RST_BUSY_CYC(BUSY)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .wr_en(wr_en), .rd_en(rd_en),
        .dout(dout), .valid(valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .data_count(data_count), .overflow(overflow), .underflow(underflow),
        .rst_busy(rst_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int txn       = 0;

    // Reference model: contents as a queue, busy as cycles remaining, sticky error bits.
    logic [DW-1:0] model_q[$];
    int            busy_left = 0;
    logic [DW-1:0] exp_dout  = '0;
    logic          exp_valid = 1'b0;
    logic          exp_ovf   = 1'b0;
    logic          exp_unf   = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [DW-1:0] rnd();
        return DW'({$urandom(), $urandom()});
    endfunction

    function automatic logic [DW-1:0] pattern(input int i);
        logic [MW-1:0] m;
        logic [PW-1:0] p;
        m = MW'(i);
        p = ~PW'(i);
        return {m, p};
    endfunction

    task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input logic rs);
        int  sz;
        bit  busy, was_full, was_empty, wa, ra;
        wr_en = w;
        rd_en = r;
        din   = d;
        rst   = rs;
        @(posedge clk);
        if (rs) begin
            model_q.delete();
            busy_left = BUSY;
            exp_valid = 1'b0;
            exp_dout  = '0;
            exp_ovf   = 1'b0;
            exp_unf   = 1'b0;
        end else begin
            busy      = (busy_left > 0);
            was_full  = (model_q.size() == DEPTH);
            was_empty = (model_q.size() == 0);
            wa = w && !was_full  && !busy;
            ra = r && !was_empty && !busy;
            if (w && was_full  && !busy) exp_ovf = 1'b1;
            if (r && was_empty && !busy) exp_unf = 1'b1;
            exp_valid = ra;
            if (ra) exp_dout = model_q.pop_front();
            if (wa) model_q.push_back(d);
            if (busy_left > 0) busy_left--;
        end
        #1;
        sz = model_q.size();
        txn++;
        $display("txn %0d: rst=%0b wr=%0b rd=%0b din=%h -> valid=%0b dout=%h count=%0d",
                 txn, rs, w, r, d, valid, dout, data_count);
        chk("dout",         64'(dout),         64'(exp_dout));
        chk("valid",        64'(valid),        64'(exp_valid));
        chk("data_count",   64'(data_count),   64'(sz));
        chk("full",         64'(full),         64'(sz == DEPTH));
        chk("empty",        64'(empty),        64'(sz == 0));
        chk("almost_full",  64'(almost_full),  64'(sz >= AF));
        chk("almost_empty", 64'(almost_empty), 64'(sz <= AE));
        chk("overflow",     64'(overflow),     64'(exp_ovf));
        chk("underflow",    64'(underflow),    64'(exp_unf));
        chk("rst_busy",     64'(rst_busy),     64'(busy_left > 0));
    endtask

    // Counts cycles with rst low and rst_busy high, pushing writes that must be ignored.
    task automatic busy_window();
        int n = 0;
        while (rst_busy === 1'b1 && n < 20) begin
            n++;
            step(1'b1, 1'b0, rnd(), 1'b0);
        end
        chk("rst_busy_len", 64'(n), 64'(BUSY));
        chk("idle_count", 64'(data_count), 64'd0);
    endtask

    initial begin
        logic [DW-1:0] w;
        int guard;
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = '0;

        step(1'b1, 1'b0, rnd(), 1'b1);
        step(1'b1, 1'b0, rnd(), 1'b1);
        chk("reset_dout", 64'(dout), 64'd0);
        busy_window();

        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, pattern(i), 1'b0);
        chk("fill_full", 64'(full), 64'd1);

        step(1'b1, 1'b1, rnd(), 1'b0);
        chk("full_rw_ovf",   64'(overflow),   64'd1);
        chk("full_rw_count", 64'(data_count), 64'(DEPTH - 1));
        chk("full_rw_dout",  64'(dout),       64'(pattern(0)));

        guard = 0;
        while (model_q.size() > 0 && guard < 4 * DEPTH) begin
            guard++;
            step(1'b0, 1'b1, '0, 1'b0);
        end
        chk("drain_empty", 64'(empty), 64'd1);
        chk("drain_last",  64'(dout),  64'(pattern(DEPTH - 1)));

        w = rnd();
        step(1'b1, 1'b1, w, 1'b0);
        chk("empty_rw_unf",   64'(underflow),  64'd1);
        chk("empty_rw_valid", 64'(valid),      64'd0);
        chk("empty_rw_count", 64'(data_count), 64'd1);
        step(1'b0, 1'b1, '0, 1'b0);
        chk("empty_rw_read", 64'(dout), 64'(w));

        for (int i = 0; i < DEPTH / 2; i++) step(1'b1, 1'b0, rnd(), 1'b0);
        for (int i = 0; i < 3 * DEPTH; i++) step(1'b1, 1'b1, rnd(), 1'b0);
        chk("wrap_count", 64'(data_count), 64'(DEPTH / 2));

        for (int i = 0; i < 200; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd(), 1'b0);

        guard = 0;
        while (model_q.size() != 10 && guard < 4 * DEPTH) begin
            guard++;
            if (model_q.size() < 10) step(1'b1, 1'b0, rnd(), 1'b0);
            else                     step(1'b0, 1'b1, '0, 1'b0);
        end
        chk("pre_rst_count", 64'(data_count), 64'd10);
        step(1'b0, 1'b1, '0, 1'b1);
        chk("rst_mid_valid", 64'(valid), 64'd0);
        chk("rst_mid_empty", 64'(empty), 64'd1);
        chk("rst_mid_ovf",   64'(overflow), 64'd0);

        step(1'b1, 1'b0, rnd(), 1'b0);
        step(1'b1, 1'b0, rnd(), 1'b0);
        step(1'b0, 1'b0, '0, 1'b1);
        busy_window();

        for (int i = 0; i < 40; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd(), 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
